// File: rtl/uart_fifo_if.sv
// Write/read handshake bundle between the 8051 bus side and the UART FIFO.
// UART_FIFO_LEVEL_EN adds the data_avail/room_avail level outputs.
interface uart_fifo_if #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  w_pt_reset;
  logic                  w_en;
  logic [FIFO_WIDTH-1:0] w_data;
  logic                  r_pt_reset;
  logic                  r_en;
  logic [FIFO_WIDTH-1:0] r_data;
  logic                  is_empty;
  logic                  is_full;

`ifdef UART_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0]   data_avail;
  logic [ADDR_WIDTH:0]   room_avail;

  modport master (
    output w_pt_reset, w_en, w_data, r_pt_reset, r_en,
    input  r_data, is_empty, is_full, data_avail, room_avail
  );

  modport slave (
    input  w_pt_reset, w_en, w_data, r_pt_reset, r_en,
    output r_data, is_empty, is_full, data_avail, room_avail
  );
`else
  modport master (
    output w_pt_reset, w_en, w_data, r_pt_reset, r_en,
    input  r_data, is_empty, is_full
  );

  modport slave (
    input  w_pt_reset, w_en, w_data, r_pt_reset, r_en,
    output r_data, is_empty, is_full
  );
`endif

endinterface

// File: rtl/uart_fifo.sv
// Single-clock byte FIFO between the 8051 core bus and the UART shifter.
// Define UART_FIFO_LEVEL_EN to drive the data_avail/room_avail level outputs.
module uart_fifo #(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_fifo_if.slave    bus
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH-1:0] r_data_q, r_data_d;
  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic empty, full;
  logic wr_accept, rd_accept;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                 (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  // Pointer clears win over the enables, so no write or read sneaks through.
  assign wr_accept = bus.w_pt_reset && bus.w_en && !full;
  assign rd_accept = bus.r_pt_reset && bus.r_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (!bus.w_pt_reset) begin
      wr_ptr_d = '0;
    end else if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    r_data_d = r_data_q;
    if (!bus.r_pt_reset) begin
      rd_ptr_d = '0;
    end else if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      r_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      r_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      r_data_q <= r_data_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.w_data;
    end
  end

  assign bus.r_data   = r_data_q;
  assign bus.is_empty = empty;
  assign bus.is_full  = full;

`ifdef UART_FIFO_LEVEL_EN
  logic [PtrW-1:0] level;

  // Natural PtrW-bit wrap gives the difference modulo 2*FIFO_DEPTH.
  assign level          = wr_ptr_q - rd_ptr_q;
  assign bus.data_avail = level;
  assign bus.room_avail = PtrW'(FIFO_DEPTH) - level;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: reset, fill, drain, wrap, concurrent, flush, async abort.
// Level outputs are checked when UART_FIFO_LEVEL_EN is defined.
module tb_uart_fifo;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  uart_fifo_if #(.FIFO_WIDTH(8), .ADDR_WIDTH(4)) bus_if ();

  uart_fifo #(
    .FIFO_WIDTH(8),
    .FIFO_DEPTH(16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags plus optional level outputs against the bench-tracked entry count.
  task automatic chk_state(input string tag, input int cnt);
    chk({tag, ".empty"}, 32'(bus_if.is_empty), 32'(cnt == 0));
    chk({tag, ".full"},  32'(bus_if.is_full),  32'(cnt == 16));
`ifdef UART_FIFO_LEVEL_EN
    chk({tag, ".data_avail"}, 32'(bus_if.data_avail), 32'(cnt));
    chk({tag, ".room_avail"}, 32'(bus_if.room_avail), 32'(16 - cnt));
`endif
  endtask

  // Drive one cycle of inputs, clock it, and settle 1 time unit past the edge.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                     input logic wclr_n, input logic rclr_n);
    bus_if.w_en       = we;
    bus_if.w_data     = wd;
    bus_if.r_en       = re;
    bus_if.w_pt_reset = wclr_n;
    bus_if.r_pt_reset = rclr_n;
    @(posedge clk);
    #1;
    bus_if.w_en       = 1'b0;
    bus_if.r_en       = 1'b0;
    bus_if.w_pt_reset = 1'b1;
    bus_if.r_pt_reset = 1'b1;
  endtask

  initial begin
    int cnt;
    n_vec = 0;
    n_err = 0;
    cnt   = 0;
    rst_n = 1'b0;
    bus_if.w_en       = 1'b0;
    bus_if.w_data     = 8'h00;
    bus_if.r_en       = 1'b0;
    bus_if.w_pt_reset = 1'b1;
    bus_if.r_pt_reset = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst.r_data", 32'(bus_if.r_data), 32'h00);
    chk_state("rst", 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_state("post_rst", 0);

    // Fill 0x01..0x10, then a dropped 0xFF
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b1, 1'b1);
      cnt++;
      chk_state($sformatf("fill%0d", i), cnt);
    end
    cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    chk_state("fill_over", cnt);

    // Drain in order; extra read holds last data
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      cnt--;
      chk($sformatf("drain%0d.data", i), 32'(bus_if.r_data), 32'(i));
      chk_state($sformatf("drain%0d", i), cnt);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("drain_under.data", 32'(bus_if.r_data), 32'h10);
    chk_state("drain_under", 0);

    // Wrap: 10 in/out, then a full 16 in/out across the pointer wrap
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b1, 1'b1);
    chk_state("wrap_w10", 10);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      chk($sformatf("wrap_r10_%0d", i), 32'(bus_if.r_data), 32'(8'h20 + i));
    end
    chk_state("wrap_r10", 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b1);
    chk_state("wrap_w16", 16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      chk($sformatf("wrap_r16_%0d", i), 32'(bus_if.r_data), 32'(8'h40 + i));
    end
    chk_state("wrap_r16", 0);

    // Concurrent at count 5 for 20 cycles
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 8'(8'h65 + k), 1'b1, 1'b1, 1'b1);
      chk($sformatf("conc%0d.data", k), 32'(bus_if.r_data), 32'(8'h60 + k));
      chk_state($sformatf("conc%0d", k), 5);
    end
    // Queue holds 0x74..0x78; top up to full with 0x79..0x83
    for (int i = 0; i < 11; i++) cyc(1'b1, 8'(8'h79 + i), 1'b0, 1'b1, 1'b1);
    chk_state("conc_full", 16);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1);
    chk("full_rw.data", 32'(bus_if.r_data), 32'h74);
    chk_state("full_rw", 15);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      chk($sformatf("full_rw_drain%0d", i), 32'(bus_if.r_data), 32'(8'h75 + i));
    end
    chk_state("full_rw_drained", 0);

    // Empty plus read plus write: no fall-through
    cyc(1'b1, 8'h99, 1'b1, 1'b1, 1'b1);
    chk("empty_rw.data", 32'(bus_if.r_data), 32'h83);
    chk_state("empty_rw", 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("empty_rw_rd.data", 32'(bus_if.r_data), 32'h99);
    chk_state("empty_rw_rd", 0);

    // Flush with 7 entries; clears beat simultaneous enables
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1, 1'b1);
    chk_state("pre_flush", 7);
    cyc(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
    chk("flush.data", 32'(bus_if.r_data), 32'h99);
    chk_state("flush", 0);
    cyc(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1);
    chk_state("flush_w", 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("flush_rt.data", 32'(bus_if.r_data), 32'h5A);
    chk_state("flush_rt", 0);

    // Async reset mid-transfer drops queued data without a clock edge
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("abort_pre.data", 32'(bus_if.r_data), 32'hC0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.data", 32'(bus_if.r_data), 32'h00);
    chk_state("abort", 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("abort_rd.data", 32'(bus_if.r_data), 32'h00);
    chk_state("abort_rd", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
